// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types and default sizing for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int N_DEF    = 24;
  localparam int NREQ_DEF = 4;

  // IDLE: grant follows the arbiter; LOCK: grant frozen until the last flit.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Request/result/adder bundle between the flit sources, the scheduler and the shared adder.
interface adder_rr_scheduler_if
  import adder_sched_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*N-1:0] req_op1;
  logic [NREQ*N-1:0] req_op2;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic [N-1:0]      add_sum;
  logic              res_valid;
  logic [N-1:0]      res_sum;
  logic [IDW-1:0]    res_id;
  logic              res_last;
  logic              res_ready;
  logic              busy;

  // Environment side: sources, result sink and the external adder.
  modport master (
    output req_valid, req_last, req_op1, req_op2, add_sum, res_ready,
    input  req_ready, add_a, add_b, res_valid, res_sum, res_id, res_last, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_last, req_op1, req_op2, add_sum, res_ready,
    output req_ready, add_a, add_b, res_valid, res_sum, res_id, res_last, busy
  );

endinterface

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, circularly.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_id
);

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int idx;
    o_gnt    = '0;
    o_gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(i_ptr) + k) % NREQ;
      if (o_gnt == '0 && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Packet-granular round-robin sharing of one external combinational adder,
// with an operand stage (drives the adder) and a result stage (captures the sum).
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input logic           clk,
  input logic           rst,
  adder_rr_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_ptr, r_grant, w_arb_id, w_gnt_id, w_ptr_nxt;
  logic [NREQ-1:0]   w_arb_gnt, w_lock_1h;
  logic              w_s1_ok, w_s2_ok, w_accept, w_acc_last;
  logic [N-1:0]      w_op1, w_op2;

  logic [N-1:0]      r_add_a_p1, r_add_b_p1;
  logic [IDW-1:0]    r_id_p1;
  logic              r_last_p1, r_vld_p1;

  logic [N-1:0]      r_sum_p2;
  logic [IDW-1:0]    r_id_p2;
  logic              r_last_p2, r_vld_p2;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_arb_gnt),
    .o_gnt_id (w_arb_id)
  );

  assign w_gnt_id   = (r_state == LOCK) ? r_grant : w_arb_id;
  assign w_s2_ok    = !r_vld_p2 || bus.res_ready;
  assign w_s1_ok    = !r_vld_p1 || w_s2_ok;
  assign w_accept   = |(bus.req_valid & bus.req_ready);
  assign w_acc_last = w_accept && bus.req_last[w_gnt_id];
  assign w_ptr_nxt  = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);

  // Decode the frozen grant and select the granted source's operands.
  always_comb begin
    w_lock_1h = '0;
    w_op1     = '0;
    w_op2     = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (r_grant == IDW'(r)) w_lock_1h[r] = 1'b1;
      if (w_gnt_id == IDW'(r)) begin
        w_op1 = bus.req_op1[r*N +: N];
        w_op2 = bus.req_op2[r*N +: N];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: lock on a non-last flit, release on the last one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_acc_last) w_state_nxt = LOCK;
      LOCK:    if (w_acc_last)              w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready only to the granted source, and only while S1 can take a flit.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && w_s1_ok) bus.req_ready = (r_state == LOCK) ? w_lock_1h : w_arb_gnt;
  end

  // Grant capture while idle, pointer advance past the source that finished a packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      if (r_state == IDLE) r_grant <= w_arb_id;
      if (w_acc_last)      r_ptr   <= w_ptr_nxt;
    end
  end

  // ---- Stage 1: operand register; add_a/add_b hold their value when idle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_add_a_p1 <= '0;
      r_add_b_p1 <= '0;
      r_id_p1    <= '0;
      r_last_p1  <= 1'b0;
      r_vld_p1   <= 1'b0;
    end else if (w_accept) begin
      r_add_a_p1 <= w_op1;
      r_add_b_p1 <= w_op2;
      r_id_p1    <= w_gnt_id;
      r_last_p1  <= bus.req_last[w_gnt_id];
      r_vld_p1   <= 1'b1;
    end else if (w_s2_ok) begin
      r_vld_p1   <= 1'b0;
    end
  end

  // ---- Stage 2: result register capturing the external adder's sum ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_p2  <= '0;
      r_id_p2   <= '0;
      r_last_p2 <= 1'b0;
      r_vld_p2  <= 1'b0;
    end else if (r_vld_p1 && w_s2_ok) begin
      r_sum_p2  <= bus.add_sum;
      r_id_p2   <= r_id_p1;
      r_last_p2 <= r_last_p1;
      r_vld_p2  <= 1'b1;
    end else if (bus.res_ready) begin
      r_vld_p2  <= 1'b0;
    end
  end

  assign bus.add_a     = r_add_a_p1;
  assign bus.add_b     = r_add_b_p1;
  assign bus.res_valid = r_vld_p2;
  assign bus.res_sum   = r_sum_p2;
  assign bus.res_id    = r_id_p2;
  assign bus.res_last  = r_last_p2;
  assign bus.busy      = (r_state == LOCK) || r_vld_p1 || r_vld_p2;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: flit sources, external adder and a result log.
module tb_adder_rr_scheduler;
  localparam int N    = 24;
  localparam int NREQ = 4;
  localparam int DEPTH = 64;
  localparam int LOGSZ = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

  adder_rr_scheduler #(.N(N), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External shared adder, sum modulo 2^N.
  assign bus.add_sum = bus.add_a + bus.add_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_acc, first_res;
  int onehot_err = 0;

  logic [N-1:0] src_op1 [NREQ][DEPTH];
  logic [N-1:0] src_op2 [NREQ][DEPTH];
  logic         src_last[NREQ][DEPTH];
  int           src_hd[NREQ];
  int           src_tl[NREQ];

  logic [N-1:0] exp_sum[LOGSZ];
  int           exp_id [LOGSZ];
  logic         exp_last[LOGSZ];
  int           exp_n;
  logic [N-1:0] got_sum[LOGSZ];
  int           got_id [LOGSZ];
  logic         got_last[LOGSZ];
  int           got_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic src_push(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input logic l);
    src_op1[r][src_tl[r]] = a;
    src_op2[r][src_tl[r]] = b;
    src_last[r][src_tl[r]] = l;
    src_tl[r]++;
  endtask

  task automatic exp_push(input int id, input logic [N-1:0] s, input logic l);
    exp_sum[exp_n] = s;
    exp_id[exp_n] = id;
    exp_last[exp_n] = l;
    exp_n++;
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      if (src_hd[r] < src_tl[r]) begin
        bus.req_valid[r] = 1'b1;
        bus.req_last[r]  = src_last[r][src_hd[r]];
        bus.req_op1[r*N +: N] = src_op1[r][src_hd[r]];
        bus.req_op2[r*N +: N] = src_op2[r][src_hd[r]];
      end else begin
        bus.req_valid[r] = 1'b0;
        bus.req_last[r]  = 1'b0;
      end
    end
  endtask

  task automatic src_clear();
    for (int r = 0; r < NREQ; r++) begin
      src_hd[r] = 0;
      src_tl[r] = 0;
    end
    drive();
  endtask

  task automatic sb_clear();
    exp_n = 0;
    got_n = 0;
  endtask

  // One clock: sample handshakes on the falling edge, advance sources after the rising edge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    if ($countones(bus.req_ready) > 1) onehot_err++;
    if (acc != '0 && first_acc < 0) first_acc = cyc;
    if (bus.res_valid && bus.res_ready && got_n < LOGSZ) begin
      got_sum[got_n]  = bus.res_sum;
      got_id[got_n]   = int'(bus.res_id);
      got_last[got_n] = bus.res_last;
      got_n++;
      if (first_res < 0) first_res = cyc;
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < NREQ; r++) if (acc[r]) src_hd[r]++;
    drive();
    cyc++;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (got_n < n && b > 0) begin
      step();
      b--;
    end
    chk({tag, "_count"}, got_n, n);
  endtask

  task automatic sb_check(input string tag);
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      chk($sformatf("%s_sum%0d", tag, i), got_sum[i], exp_sum[i]);
      chk($sformatf("%s_id%0d", tag, i), got_id[i], exp_id[i]);
      chk($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_clear();
  endtask

  initial begin
    logic [N-1:0] a, b, held_sum, sa, sb;
    int toggles;

    rst = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_op1 = '0;
    bus.req_op2 = '0;
    src_clear();
    sb_clear();
    first_acc = -1;
    first_res = -1;

    // Reset state, with a request present to prove ready is held low.
    bus.req_valid = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_sum", bus.res_sum, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_last", bus.res_last, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_b", bus.add_b, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    bus.req_valid = '0;
    rst = 1'b0;

    // T1: req0, three flits.
    src_push(0, 24'h1, 24'h2, 1'b0);
    src_push(0, 24'h5, 24'h7, 1'b0);
    src_push(0, 24'h10, 24'h20, 1'b1);
    exp_push(0, 24'h3, 1'b0);
    exp_push(0, 24'hC, 1'b0);
    exp_push(0, 24'h30, 1'b1);
    drive();
    run_until("t1", 3, 30);
    sb_check("t1");
    chk("t1_latency", first_res - first_acc, 2);

    // T2: carry out of the top bit is dropped.
    sb_clear();
    src_push(0, 24'hFFFFFF, 24'h000001, 1'b1);
    exp_push(0, 24'h000000, 1'b1);
    drive();
    run_until("t2", 1, 20);
    sb_check("t2");

    // T3: req0 and req1 both valid from the start, 20-flit packets each.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      a = 24'h000100 + 24'(i);
      b = 24'h000010 * 24'(i);
      src_push(0, a, b, i == 19);
      exp_push(0, a + b, i == 19);
    end
    for (int i = 0; i < 20; i++) begin
      a = 24'h800000 + 24'(i);
      b = 24'h7FFFF0;
      src_push(1, a, b, i == 19);
    end
    for (int i = 0; i < 20; i++) exp_push(1, 24'h800000 + 24'(i) + 24'h7FFFF0, i == 19);
    drive();
    run_until("t3", 40, 200);
    sb_check("t3");

    // T4: after req3 finishes, the pointer wraps so req0 wins over req3.
    do_reset();
    src_push(3, 24'h30, 24'h1, 1'b0);
    src_push(3, 24'h30, 24'h2, 1'b1);
    exp_push(3, 24'h31, 1'b0);
    exp_push(3, 24'h32, 1'b1);
    drive();
    run_until("t4a", 2, 30);
    src_push(0, 24'h40, 24'h1, 1'b0);
    src_push(0, 24'h40, 24'h2, 1'b1);
    src_push(3, 24'h50, 24'h1, 1'b0);
    src_push(3, 24'h50, 24'h2, 1'b1);
    exp_push(0, 24'h41, 1'b0);
    exp_push(0, 24'h42, 1'b1);
    exp_push(3, 24'h51, 1'b0);
    exp_push(3, 24'h52, 1'b1);
    drive();
    run_until("t4", 6, 40);
    sb_check("t4");

    // T5: result backpressure for five cycles in the middle of a packet.
    sb_clear();
    for (int i = 0; i < 8; i++) begin
      a = 24'h001000 + 24'(i);
      b = 24'h000010 * 24'(i);
      src_push(1, a, b, i == 7);
      exp_push(1, a + b, i == 7);
    end
    drive();
    run_until("t5a", 2, 30);
    bus.res_ready = 1'b0;
    held_sum = bus.res_sum;
    for (int s = 0; s < 5; s++) begin
      step();
      if (s == 1) chk("t5_ready_drop", bus.req_ready, 0);
    end
    chk("t5_hold_valid", bus.res_valid, 1);
    chk("t5_hold_sum", bus.res_sum, held_sum);
    chk("t5_no_log", got_n, 2);
    bus.res_ready = 1'b1;
    run_until("t5", 8, 40);
    sb_check("t5");

    // T6: idle after drain, adder operands must not move.
    chk("t6_add_a", bus.add_a, 24'h001007);
    chk("t6_add_b", bus.add_b, 24'h000070);
    sa = bus.add_a;
    sb = bus.add_b;
    toggles = 0;
    for (int s = 0; s < 7; s++) begin
      step();
      if (bus.add_a !== sa || bus.add_b !== sb) toggles++;
      if (s == 0) chk("t6_busy", bus.busy, 0);
    end
    chk("t6_toggles", toggles, 0);

    // T7: reset in the middle of a packet, then req2 alone gets the first grant.
    sb_clear();
    for (int i = 0; i < 6; i++) src_push(0, 24'h000111 + 24'(i), 24'h000222, i == 5);
    drive();
    run_until("t7a", 2, 30);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_res_valid", bus.res_valid, 0);
    chk("t7_rst_res_sum", bus.res_sum, 0);
    chk("t7_rst_add_a", bus.add_a, 0);
    chk("t7_rst_add_b", bus.add_b, 0);
    chk("t7_rst_req_ready", bus.req_ready, 0);
    chk("t7_rst_busy", bus.busy, 0);
    src_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_clear();
    for (int i = 0; i < 3; i++) begin
      a = 24'hFFFFF0 + 24'(i);
      src_push(2, a, 24'h20, i == 2);
      exp_push(2, 24'h10 + 24'(i), i == 2);
    end
    drive();
    step();
    src_push(1, 24'h7, 24'h8, 1'b0);
    src_push(1, 24'h9, 24'hA, 1'b1);
    exp_push(1, 24'hF, 1'b0);
    exp_push(1, 24'h13, 1'b1);
    drive();
    run_until("t7", 5, 40);
    sb_check("t7");

    chk("ready_onehot", onehot_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
